// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NUM_REQ requesters.
// A single registered result slot holds each answer until its owner takes it.

package alu_pkg;
  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD                   = 4'd0,
    ALU_SUB                   = 4'd1,
    ALU_AND                   = 4'd2,
    ALU_OR                    = 4'd3,
    ALU_XOR                   = 4'd4,
    ALU_SLL                   = 4'd5,
    ALU_SRL                   = 4'd6,
    ALU_SRA                   = 4'd7,
    ALU_COMPARE_LESS_SIGNED   = 4'd8,
    ALU_COMPARE_LESS_UNSIGNED = 4'd9,
    ALU_COMPARE_EQUAL         = 4'd10,
    ALU_INVALID               = 4'd15
  } alu_op_t;
endpackage

module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = alu_pkg::XLEN
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  alu_pkg::alu_op_t        req_operation [NUM_REQ],
  input  logic [XLEN-1:0]         req_operand_1 [NUM_REQ],
  input  logic [XLEN-1:0]         req_operand_2 [NUM_REQ],
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [XLEN-1:0]         resp_result,
  output logic                    resp_nonzero,
  output logic                    resp_error,
  output logic                    busy
);
  import alu_pkg::*;

  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int SHAMT_W = $clog2(XLEN);
  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

  typedef logic [PTR_W-1:0] idx_t;
  typedef enum logic { S_EMPTY, S_FULL } slot_state_t;
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            error;
  } alu_out_t;

  slot_state_t state;
  idx_t        owner;
  idx_t        ptr;
  idx_t        win_idx;
  idx_t        cand;
  logic        win_found;
  logic        drain;
  logic        slot_free;
  logic        accept;
  alu_out_t    alu_out;

  // One extra bit in the sum keeps base + offset from overflowing before the wrap.
  function automatic idx_t wrap_add(idx_t base, logic [PTR_W:0] offset);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + offset;
    if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
    return sum[PTR_W-1:0];
  endfunction

  function automatic alu_out_t alu_compute(alu_op_t op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    alu_out_t         o;
    logic [SHAMT_W-1:0] sh;
    sh       = b[SHAMT_W-1:0];
    o.result = '0;
    o.error  = 1'b0;
    case (op)
      ALU_ADD:                   o.result = a + b;
      ALU_SUB:                   o.result = a - b;
      ALU_AND:                   o.result = a & b;
      ALU_OR:                    o.result = a | b;
      ALU_XOR:                   o.result = a ^ b;
      ALU_SLL:                   o.result = a << sh;
      ALU_SRL:                   o.result = a >> sh;
      ALU_SRA:                   o.result = $signed(a) >>> sh;
      ALU_COMPARE_LESS_SIGNED:   o.result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_COMPARE_LESS_UNSIGNED: o.result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_COMPARE_EQUAL:         o.result = {{(XLEN-1){1'b0}}, (a == b)};
      // ALU_INVALID and every undefined encoding land here with a clean zero result.
      default:                   o.error  = 1'b1;
    endcase
    return o;
  endfunction

  assign drain     = (state == S_FULL) && resp_ready[owner];
  assign slot_free = (state == S_EMPTY) || drain;
  assign accept    = win_found && slot_free && reset_n;
  assign busy      = (state == S_FULL);

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_add(ptr, (PTR_W+1)'(k));
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (state == S_FULL) resp_valid[owner] = 1'b1;
  end

  assign alu_out = alu_compute(req_operation[win_idx], req_operand_1[win_idx],
                               req_operand_2[win_idx]);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_EMPTY;
      owner        <= '0;
      ptr          <= '0;
      resp_result  <= '0;
      resp_nonzero <= 1'b0;
      resp_error   <= 1'b0;
    end else if (accept) begin
      state        <= S_FULL;
      owner        <= win_idx;
      ptr          <= wrap_add(win_idx, (PTR_W+1)'(1));
      resp_result  <= alu_out.result;
      resp_nonzero <= |alu_out.result;
      resp_error   <= alu_out.error;
    end else if (drain) begin
      state <= S_EMPTY;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a random phase,
// all compared against a transaction-level slot/round-robin model.

module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  alu_op_t         req_operation [N];
  logic [XLEN-1:0] req_operand_1 [N];
  logic [XLEN-1:0] req_operand_2 [N];
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [XLEN-1:0] resp_result;
  logic            resp_nonzero;
  logic            resp_error;
  logic            busy;

  int n_cmp  = 0;
  int n_fail = 0;

  bit              m_full;
  int              m_owner;
  int              m_ptr;
  int              last_grant;
  logic [XLEN-1:0] m_result;
  bit              m_error;

  alu_arbiter #(.NUM_REQ(N), .XLEN(XLEN)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_operation(req_operation),
    .req_operand_1(req_operand_1),
    .req_operand_2(req_operand_2),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_result  (resp_result),
    .resp_nonzero (resp_nonzero),
    .resp_error   (resp_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic; returns {error, result}.
  function automatic logic [XLEN:0] ref_alu(alu_op_t op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    logic [XLEN-1:0]   r;
    logic [2*XLEN-1:0] ext;
    bit                err;
    int unsigned       sh;
    sh  = b % XLEN;
    err = 1'b0;
    r   = '0;
    ext = {{XLEN{a[XLEN-1]}}, a};
    case (op)
      ALU_ADD:                   r = a + b;
      ALU_SUB:                   r = a - b;
      ALU_AND:                   r = a & b;
      ALU_OR:                    r = a | b;
      ALU_XOR:                   r = a ^ b;
      ALU_SLL:                   r = a << sh;
      ALU_SRL:                   r = a >> sh;
      ALU_SRA:                   r = XLEN'(ext >> sh);
      ALU_COMPARE_LESS_SIGNED:   r = ($signed(a) < $signed(b)) ? 1 : 0;
      ALU_COMPARE_LESS_UNSIGNED: r = (a < b) ? 1 : 0;
      ALU_COMPARE_EQUAL:         r = (a == b) ? 1 : 0;
      default:                   err = 1'b1;
    endcase
    return {err, r};
  endfunction

  task automatic set_req(input int i, input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    req_operation[i] = op;
    req_operand_1[i] = a;
    req_operand_2[i] = b;
  endtask

  // Compares every output with the model, then advances both across one clock edge.
  task automatic clock_cycle();
    bit              drain, free, found;
    int              win;
    logic [N-1:0]    exp_ready, exp_valid;
    logic [XLEN:0]   ref_out;
    #1;
    drain = m_full && resp_ready[m_owner];
    free  = !m_full || drain;
    found = 1'b0;
    win   = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (!found && req_valid[i]) begin
        found = 1'b1;
        win   = i;
      end
    end
    exp_ready = '0;
    if (found && free) exp_ready[win] = 1'b1;
    exp_valid = '0;
    if (m_full) exp_valid[m_owner] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    check("resp_valid", resp_valid, exp_valid);
    check("busy", busy, m_full);
    if (m_full) begin
      check("resp_result", resp_result, m_result);
      check("resp_nonzero", resp_nonzero, m_result != 0);
      check("resp_error", resp_error, m_error);
    end
    ref_out = '0;
    if (found && free) ref_out = ref_alu(req_operation[win], req_operand_1[win], req_operand_2[win]);
    last_grant = -1;
    @(posedge clk);
    #2;
    if (found && free) begin
      m_full     = 1'b1;
      m_owner    = win;
      m_ptr      = (win + 1) % N;
      m_result   = ref_out[XLEN-1:0];
      m_error    = ref_out[XLEN];
      last_grant = win;
    end else if (drain) begin
      m_full = 1'b0;
    end
  endtask

  initial begin
    req_valid  = '0;
    resp_ready = '1;
    for (int i = 0; i < N; i++) set_req(i, ALU_ADD, 0, 0);
    m_full  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;

    // Reset state, with requests already pending.
    req_valid = 2'b11;
    #12;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", resp_result, 0);
    check("rst_nonzero", resp_nonzero, 0);
    check("rst_error", resp_error, 0);
    check("rst_req_ready", req_ready, 0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Contention: grants alternate 0,1,0,1 with back-to-back reloads.
    set_req(0, ALU_SUB, 3, 3);
    set_req(1, ALU_XOR, 32'hF0, 32'h0F);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) begin
        check("rr_result", resp_result, (k % 2 == 1) ? 32'h0 : 32'hFF);
        check("rr_nonzero", resp_nonzero, (k % 2 == 1) ? 0 : 1);
      end
      clock_cycle();
      check("rr_grant", last_grant, k % 2);
    end
    req_valid = '0;
    clock_cycle();

    // Single request: one-cycle latency, slot empty afterwards.
    req_valid = 2'b01;
    set_req(0, ALU_ADD, 5, 7);
    #1;
    check("single_ready", req_ready, 2'b01);
    clock_cycle();
    req_valid = '0;
    #1;
    check("single_valid", resp_valid, 2'b01);
    check("single_result", resp_result, 12);
    check("single_nonzero", resp_nonzero, 1);
    clock_cycle();
    #1;
    check("single_empty", busy, 0);

    // Backpressure: req1 result held while req0 waits, then drain + accept together.
    req_valid  = 2'b10;
    set_req(1, ALU_SLL, 1, 4);
    resp_ready = 2'b01;
    clock_cycle();
    req_valid = 2'b01;
    set_req(0, ALU_ADD, 100, 23);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_valid", resp_valid, 2'b10);
      check("bp_result", resp_result, 16);
      check("bp_ready", req_ready, 2'b00);
      clock_cycle();
    end
    resp_ready = 2'b11;
    #1;
    check("bp_release_ready", req_ready, 2'b01);
    clock_cycle();
    req_valid = '0;
    #1;
    check("bp_follow_valid", resp_valid, 2'b01);
    check("bp_follow_result", resp_result, 123);
    clock_cycle();

    // Invalid / undefined operations, then signed vs unsigned compare.
    req_valid = 2'b01;
    set_req(0, ALU_INVALID, 32'h1234, 32'h5678);
    clock_cycle();
    set_req(0, ALU_ADD, 1, 1);
    #1;
    check("inv_valid", resp_valid, 2'b01);
    check("inv_result", resp_result, 0);
    check("inv_nonzero", resp_nonzero, 0);
    check("inv_error", resp_error, 1);
    clock_cycle();
    set_req(0, alu_op_t'(4'd12), 7, 9);
    #1;
    check("ok_error", resp_error, 0);
    check("ok_result", resp_result, 2);
    clock_cycle();
    set_req(0, ALU_COMPARE_LESS_SIGNED, 32'hFFFF_FFFF, 1);
    #1;
    check("undef_error", resp_error, 1);
    check("undef_result", resp_result, 0);
    clock_cycle();
    set_req(0, ALU_COMPARE_LESS_UNSIGNED, 32'hFFFF_FFFF, 1);
    #1;
    check("lt_signed", resp_result, 1);
    clock_cycle();
    req_valid = '0;
    #1;
    check("lt_unsigned", resp_result, 0);
    clock_cycle();

    // Random traffic against the model.
    repeat (400) begin
      for (int i = 0; i < N; i++)
        set_req(i, alu_op_t'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom(),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom());
      req_valid  = N'($urandom_range(0, 3));
      resp_ready = N'($urandom_range(0, 3));
      clock_cycle();
    end
    req_valid  = '0;
    resp_ready = '1;
    clock_cycle();

    // Reset while FULL, asserted between edges.
    req_valid  = 2'b01;
    set_req(0, ALU_ADD, 2, 3);
    resp_ready = '0;
    clock_cycle();
    req_valid = 2'b11;
    #1;
    check("pre_rst_busy", busy, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", resp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", req_ready, 0);
    m_full  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    @(posedge clk);
    #2;
    reset_n    = 1'b1;
    resp_ready = '1;
    #1;
    check("post_rst_ready", req_ready, 2'b01);
    clock_cycle();
    check("post_rst_grant0", last_grant, 0);
    clock_cycle();
    check("post_rst_grant1", last_grant, 1);
    req_valid = '0;
    clock_cycle();
    clock_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares a single combinational ALU instance between NUM_REQ requesters, for example the execute stage, the branch-compare path and the address-generation path.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Grants are round-robin. At most one operation is held in a registered result slot.
- The arbiter holds the result until the granted requester accepts it.

Parameters:
- NUM_REQ, 2: number of requesters. Legal range 2..8.
- XLEN, 32: datapath width. Must match the package XLEN.

Ports:
- clk  in  1: clock.
- reset_n  in  1: asynchronous, active-low reset.
- req_valid  in  NUM_REQ: request valid, one bit per requester.
- req_ready  out  NUM_REQ: request accepted this cycle. One-hot or zero.
- req_operation  in  NUM_REQ x alu_op_t: operation per requester.
- req_operand_1  in  NUM_REQ x XLEN: first operand per requester.
- req_operand_2  in  NUM_REQ x XLEN: second operand per requester.
- resp_valid  out  NUM_REQ: result valid. One-hot or zero.
- resp_ready  in  NUM_REQ: requester accepts result.
- resp_result  out  XLEN: registered ALU result, shared by all requesters.
- resp_nonzero  out  1: registered (result != 0).
- resp_error  out  1: registered flag, set when the accepted operation was ALU_INVALID or an undefined encoding.
- busy  out  1: result slot occupied.

Behaviour:
- Reset: asynchronous on reset_n low.
  - slot empty.
  - resp_valid = 0, resp_result = 0, resp_nonzero = 0, resp_error = 0, busy = 0.
  - Round-robin pointer = 0.
  - req_ready = 0 while reset_n is low.
- Slot state machine has two states:
  - EMPTY: no result held.
  - FULL: result held for owner index.
- drain = FULL & resp_ready[owner].
- slot_free = EMPTY | drain.
- Arbitration (combinational):
  - Search starts at pointer and proceeds upward with wrap-around.
  - winner = first i with req_valid[i].
  - req_ready[winner] = slot_free. All other req_ready bits are 0.
  - req_ready never depends on resp_ready of a non-owner.
- Accept = req_valid[w] & req_ready[w]. On the clock edge after accept:
  - ALU output is registered into resp_result and resp_nonzero.
  - owner = w.
  - state = FULL.
  - pointer = (w+1) mod NUM_REQ.
- Latency: resp_valid[w] rises exactly 1 cycle after accept.
- resp_valid[owner] = FULL. It stays high, with stable result/nonzero/error, until resp_ready[owner].
- Back-to-back operation: drain and a new accept in the same cycle are both legal.
  - Slot reloads with the new owner.
  - No bubble, so the sustained throughput is 1 op/cycle.
- Drain without a new accept: state goes to EMPTY. resp_result holds its last value, which is don't-care.
- Invalid operation (ALU_INVALID or undefined encoding):
  - resp_result = 0, resp_nonzero = 0, resp_error = 1.
  - Still delivered and handshaked normally. No X is ever registered.
- Pointer advances only on accept. Idle cycles leave it unchanged.
- A requester may drop req_valid before it is granted; this has no side effect.
- Request payload is sampled only in the accept cycle.
- Reset mid-operation: the held result is discarded and the slot is EMPTY immediately. No response is delivered after reset.
- Arithmetic: identical to the shared ALU, i.e. XLEN-bit wraparound add/sub, shift amount as given, compares produce 0/1.
- busy = FULL.

Test Plan:
- Single request:
  - Stimulus: req0 issues ALU_ADD 5, 7. resp_ready0 = 1.
  - Required: req_ready0 high in cycle 0. resp_valid0 high in cycle 1 with resp_result = 12 and resp_nonzero = 1. Slot EMPTY in cycle 2.
- Contention and round-robin:
  - Stimulus: req0 and req1 both hold valid continuously. req0 issues SUB 3, 3; req1 issues XOR 0xF0, 0x0F. resp_ready tied high.
  - Required: grants alternate 0, 1, 0, 1. req0 gets result 0 with nonzero = 0. req1 gets 0xFF.
- Backpressure:
  - Stimulus: req1 issues SLL 1, 4. resp_ready1 is held low for 3 cycles.
  - Required: resp_valid1 is held with resp_result = 16 stable. req_ready is 0 for all requesters during the stall.
  - Required: in the cycle resp_ready1 rises, a pending req0 is accepted, and resp_valid0 follows in the next cycle.
- Invalid operation:
  - Stimulus: req0 issues ALU_INVALID.
  - Required: resp_valid0 with resp_result = 0 and resp_error = 1. The next valid op from req0 returns resp_error = 0.
- Signed versus unsigned compare:
  - Stimulus: COMPARE_LESS_SIGNED on 0xFFFFFFFF, 1, then COMPARE_LESS_UNSIGNED on the same operands.
  - Required: first result 1, second result 0.
- Reset mid-operation:
  - Stimulus: assert reset_n low while FULL, asynchronously between edges.
  - Required: resp_valid and busy drop immediately. After release the pointer is 0, and simultaneous req0 and req1 grant req0 first.
